// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one pmem/L2 port between the LC-3b I-cache and D-cache.
// Optional performance counters are compiled in with `define ARB_PERF_COUNTERS_EN.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_igrants,
  output logic [31:0]           perf_dgrants,
  output logic [31:0]           perf_conflicts
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic i_req, d_req, pick_i, pick_d;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // On a tie the side that did not win last time is served.
  assign pick_i = i_req & (~d_req | last_grant_q);
  assign pick_d = d_req & (~i_req | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (pick_i) begin
          state_d      = S_GRANT_I;
          last_grant_d = 1'b0;
          op_write_d   = 1'b0;
          addr_d       = icache_pmem_address;
        end else if (pick_d) begin
          state_d      = S_GRANT_D;
          last_grant_d = 1'b1;
          // A simultaneous read+write is illegal; the write wins so dirty data is never lost.
          op_write_d   = dcache_pmem_write;
          addr_d       = dcache_pmem_address;
          wdata_d      = dcache_pmem_wdata;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (pmem_resp) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign pmem_read    = (state_q == S_GRANT_I) | ((state_q == S_GRANT_D) & ~op_write_q);
  assign pmem_write   = (state_q == S_GRANT_D) & op_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign icache_pmem_resp  = (state_q == S_GRANT_I) & pmem_resp;
  assign dcache_pmem_resp  = (state_q == S_GRANT_D) & pmem_resp;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  a_no_rw_collision: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_IDLE && pick_d) |-> !(dcache_pmem_read && dcache_pmem_write));

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] igrants_q, igrants_d;
  logic [31:0] dgrants_q, dgrants_d;
  logic [31:0] conflicts_q, conflicts_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    igrants_d   = igrants_q;
    dgrants_d   = dgrants_q;
    conflicts_d = conflicts_q;
    if (state_q == S_IDLE) begin
      if (pick_i) igrants_d = sat_inc(igrants_q);
      else if (pick_d) dgrants_d = sat_inc(dgrants_q);
      if (i_req && d_req) conflicts_d = sat_inc(conflicts_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      igrants_q   <= '0;
      dgrants_q   <= '0;
      conflicts_q <= '0;
    end else begin
      igrants_q   <= igrants_d;
      dgrants_q   <= dgrants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign perf_igrants   = igrants_q;
  assign perf_dgrants   = dgrants_q;
  assign perf_conflicts = conflicts_q;
`endif

endmodule
